// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 address-generation slice: response ids,
// load/store size encodings, the response record and the LS alignment rule.
package msrv32_pkg;

  localparam int XLEN = 32;

  localparam logic RESP_ID_BR = 1'b0;
  localparam logic RESP_ID_LS = 1'b1;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } resp_state_t;

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] addr;
    logic            mis;
  } resp_t;

  // Reserved size 2'b11 is always reported as a fault.
  function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic m;
    unique case (size)
      LS_BYTE: m = 1'b0;
      LS_HALF: m = lsb[0];
      LS_WORD: m = |lsb;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/msrv32_immediate_adder.sv
// Base + immediate adder; base is rs1 when iadder_src_in is set, else the PC.
module msrv32_immediate_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs_1_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            iadder_src_in,
  output logic [XLEN-1:0] iadder_out
);

  // Carry out is dropped: address wrap-around is legal.
  assign iadder_out = (iadder_src_in ? rs_1_in : pc_in) + imm_in;

endmodule

// File: rtl/msrv32_iadder_arbiter.sv
// Shares one immediate adder between the branch-target (BR) and load/store (LS)
// requesters, with a one-entry registered response tagged by the winner.
module msrv32_iadder_arbiter
  import msrv32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            br_valid_in,
  output logic            br_ready_out,
  input  logic            br_src_in,
  input  logic            br_jalr_in,
  input  logic [XLEN-1:0] br_pc_in,
  input  logic [XLEN-1:0] br_rs_1_in,
  input  logic [XLEN-1:0] br_imm_in,
  input  logic            ls_valid_in,
  output logic            ls_ready_out,
  input  logic [XLEN-1:0] ls_rs_1_in,
  input  logic [XLEN-1:0] ls_imm_in,
  input  logic [1:0]      ls_size_in,
  output logic            resp_valid_out,
  input  logic            resp_ready_in,
  output logic            resp_id_out,
  output logic [XLEN-1:0] resp_addr_out,
  output logic            resp_misaligned_out
);

  resp_state_t     state;
  resp_t           resp_q, resp_d;
  logic            last_grant;
  logic            resp_free;
  logic            br_win, ls_win, accept;
  logic            add_src;
  logic [XLEN-1:0] add_rs_1, add_imm, sum;

  assign resp_free = (state == ST_EMPTY) || resp_ready_in;

  // Round-robin favours whoever did not win last; fixed priority always picks BR.
  always_comb begin
    br_win = 1'b0;
    ls_win = 1'b0;
    if (!rst_in && resp_free) begin
      if (br_valid_in && ls_valid_in) begin
        if (FIXED_PRIO || last_grant == RESP_ID_LS) br_win = 1'b1;
        else                                        ls_win = 1'b1;
      end else if (br_valid_in) begin
        br_win = 1'b1;
      end else if (ls_valid_in) begin
        ls_win = 1'b1;
      end
    end
  end

  assign br_ready_out = br_win;
  assign ls_ready_out = ls_win;
  assign accept       = br_win || ls_win;

  // LS always adds against rs1; BR chooses rs1 or PC.
  assign add_src  = ls_win ? 1'b1       : br_src_in;
  assign add_rs_1 = ls_win ? ls_rs_1_in : br_rs_1_in;
  assign add_imm  = ls_win ? ls_imm_in  : br_imm_in;

  msrv32_immediate_adder #(.XLEN(XLEN)) u_iadder (
    .pc_in         (br_pc_in),
    .rs_1_in       (add_rs_1),
    .imm_in        (add_imm),
    .iadder_src_in (add_src),
    .iadder_out    (sum)
  );

  always_comb begin
    resp_d = '0;
    if (ls_win) begin
      resp_d.id   = RESP_ID_LS;
      resp_d.addr = sum;
      resp_d.mis  = ls_misaligned(ls_size_in, sum[1:0]);
    end else begin
      resp_d.id   = RESP_ID_BR;
      resp_d.addr = br_jalr_in ? {sum[XLEN-1:1], 1'b0} : sum;
      // IALIGN=32: bit 0 is either cleared by JALR or ignored.
      resp_d.mis  = resp_d.addr[1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_EMPTY;
      resp_q     <= '0;
      last_grant <= RESP_ID_LS;
    end else if (accept) begin
      state      <= ST_FULL;
      resp_q     <= resp_d;
      last_grant <= resp_d.id;
    end else if (resp_ready_in) begin
      state      <= ST_EMPTY;
    end
  end

  assign resp_valid_out      = (state == ST_FULL);
  assign resp_id_out         = resp_q.id;
  assign resp_addr_out       = resp_q.addr;
  assign resp_misaligned_out = resp_q.mis;

endmodule

// File: tb/tb_msrv32_iadder_arbiter.sv
// Bench for msrv32_iadder_arbiter: round-robin and fixed-priority instances
// share one stimulus stream and are compared against a behavioural model.
module tb_msrv32_iadder_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        br_valid, br_src, br_jalr;
  logic [31:0] br_pc, br_rs1, br_imm;
  logic        ls_valid;
  logic [31:0] ls_rs1, ls_imm;
  logic [1:0]  ls_size;
  logic        resp_ready;

  logic [1:0]       br_rdy, ls_rdy, r_valid, r_id, r_mis;
  logic [1:0][31:0] r_addr;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  logic        m_valid [2];
  logic        m_cmp   [2];
  logic        m_id    [2];
  logic [31:0] m_addr  [2];
  logic        m_mis   [2];
  logic        m_last  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  msrv32_iadder_arbiter #(.XLEN(32), .FIXED_PRIO(1'b0)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .br_valid_in(br_valid), .br_ready_out(br_rdy[0]), .br_src_in(br_src), .br_jalr_in(br_jalr),
    .br_pc_in(br_pc), .br_rs_1_in(br_rs1), .br_imm_in(br_imm),
    .ls_valid_in(ls_valid), .ls_ready_out(ls_rdy[0]), .ls_rs_1_in(ls_rs1), .ls_imm_in(ls_imm),
    .ls_size_in(ls_size),
    .resp_valid_out(r_valid[0]), .resp_ready_in(resp_ready), .resp_id_out(r_id[0]),
    .resp_addr_out(r_addr[0]), .resp_misaligned_out(r_mis[0])
  );

  msrv32_iadder_arbiter #(.XLEN(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in),
    .br_valid_in(br_valid), .br_ready_out(br_rdy[1]), .br_src_in(br_src), .br_jalr_in(br_jalr),
    .br_pc_in(br_pc), .br_rs_1_in(br_rs1), .br_imm_in(br_imm),
    .ls_valid_in(ls_valid), .ls_ready_out(ls_rdy[1]), .ls_rs_1_in(ls_rs1), .ls_imm_in(ls_imm),
    .ls_size_in(ls_size),
    .resp_valid_out(r_valid[1]), .resp_ready_in(resp_ready), .resp_id_out(r_id[1]),
    .resp_addr_out(r_addr[1]), .resp_misaligned_out(r_mis[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs at negedge, advance the model across the posedge.
  task automatic step();
    logic [31:0] base, sum, b_addr, l_addr;
    logic        b_mis, l_mis, free, both, e_br, e_ls;
    @(negedge clk_in);
    base   = br_src ? br_rs1 : br_pc;
    sum    = base + br_imm;
    b_addr = (br_jalr && (sum % 2 != 0)) ? sum - 1 : sum;
    b_mis  = ((b_addr / 2) % 2) != 0;
    l_addr = ls_rs1 + ls_imm;
    case (ls_size)
      2'd0:    l_mis = 1'b0;
      2'd1:    l_mis = (l_addr % 2) != 0;
      2'd2:    l_mis = (l_addr % 4) != 0;
      default: l_mis = 1'b1;
    endcase
    for (int d = 0; d < 2; d++) begin
      free = !rst_in && (!m_valid[d] || resp_ready);
      both = br_valid && ls_valid;
      e_br = free && br_valid && (!both || d == 1 || m_last[d] == 1'b1);
      e_ls = free && ls_valid && !e_br;
      chk($sformatf("d%0d br_ready", d), {31'b0, br_rdy[d]}, {31'b0, e_br});
      chk($sformatf("d%0d ls_ready", d), {31'b0, ls_rdy[d]}, {31'b0, e_ls});
      chk($sformatf("d%0d resp_valid", d), {31'b0, r_valid[d]}, {31'b0, m_valid[d]});
      if (m_cmp[d]) begin
        chk($sformatf("d%0d resp_id", d), {31'b0, r_id[d]}, {31'b0, m_id[d]});
        chk($sformatf("d%0d resp_addr", d), r_addr[d], m_addr[d]);
        chk($sformatf("d%0d resp_mis", d), {31'b0, r_mis[d]}, {31'b0, m_mis[d]});
      end
      if (rst_in) begin
        m_valid[d] = 0; m_cmp[d] = 1; m_id[d] = 0; m_addr[d] = 0; m_mis[d] = 0; m_last[d] = 1;
      end else if (e_br) begin
        m_valid[d] = 1; m_cmp[d] = 1; m_id[d] = 0; m_addr[d] = b_addr; m_mis[d] = b_mis; m_last[d] = 0;
      end else if (e_ls) begin
        m_valid[d] = 1; m_cmp[d] = 1; m_id[d] = 1; m_addr[d] = l_addr; m_mis[d] = l_mis; m_last[d] = 1;
      end else if (resp_ready) begin
        m_valid[d] = 0; m_cmp[d] = 0;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_cmp[d] = 0; m_id[d] = 0; m_addr[d] = 0; m_mis[d] = 0; m_last[d] = 1;
    end
    rst_in = 1; br_valid = 0; br_src = 0; br_jalr = 0; br_pc = 0; br_rs1 = 0; br_imm = 0;
    ls_valid = 0; ls_rs1 = 0; ls_imm = 0; ls_size = 0; resp_ready = 1;
    @(posedge clk_in); #1;
    step(); step();
    rst_in = 0;
    step();

    // Reset while FULL and stalled: held response must vanish.
    br_valid = 1; br_src = 0; br_pc = 32'h100; br_imm = 32'h20; resp_ready = 0;
    step();
    br_valid = 0;
    step();
    rst_in = 1;
    step();
    rst_in = 0;
    step(); step();

    // BR pc-relative with negative offset.
    resp_ready = 1; br_valid = 1; br_pc = 32'h1000; br_imm = 32'hFFFF_FFF8;
    step();
    br_valid = 0;
    step();

    // JALR bit-0 clearing and alignment.
    br_valid = 1; br_src = 1; br_jalr = 1; br_rs1 = 32'h2003; br_imm = 0;
    step();
    br_rs1 = 32'h2001;
    step();
    br_valid = 0; br_jalr = 0;
    step();

    // LS alignment by size: word, half, reserved, byte.
    ls_valid = 1; ls_rs1 = 32'h3000; ls_imm = 32'h2; ls_size = 2'b10;
    step();
    ls_size = 2'b01; step();
    ls_size = 2'b11; step();
    ls_size = 2'b00; step();
    ls_valid = 0;
    step();

    // Continuous conflict.
    br_valid = 1; ls_valid = 1; br_src = 0; br_pc = 32'h4000; br_imm = 32'h10;
    ls_rs1 = 32'h5000; ls_imm = 32'h4; ls_size = 2'b10;
    repeat (5) step();

    // Backpressure, then drain + accept with address wrap.
    resp_ready = 0;
    repeat (3) step();
    br_valid = 0; ls_rs1 = 32'hFFFF_FFFC; ls_imm = 32'h8; resp_ready = 1;
    step();
    ls_valid = 0;
    step(); step();

    // Randomized traffic with occasional reset.
    repeat (400) begin
      rst_in     = ($urandom_range(0, 49) == 0);
      br_valid   = $urandom_range(0, 1);
      ls_valid   = $urandom_range(0, 1);
      br_src     = $urandom_range(0, 1);
      br_jalr    = $urandom_range(0, 1);
      br_pc      = $urandom;
      br_rs1     = $urandom;
      br_imm     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      ls_rs1     = $urandom;
      ls_imm     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      ls_size    = 2'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
